// File: rtl/ddr_rd_pkg.sv
// ddr_rd_pkg: state encoding and bus geometry shared by the DDR line-read responder
package ddr_rd_pkg;
  typedef enum logic [1:0] {IDLE, AR, DATA, DONE} state_t;
  localparam int BEAT_ADDR_INC = 8;
  localparam int DDR_DATA_WIDTH = 256;
endpackage

// File: rtl/ddr_rd_burst_calc.sv
// ddr_rd_burst_calc: clamps the remaining line length to one AXI burst (beats and arlen)
module ddr_rd_burst_calc #(
  parameter int LEN_WIDTH = 16,
  parameter int BURST_LEN = 16
) (
  input  logic [LEN_WIDTH-1:0] remaining,
  output logic [8:0]           beats,
  output logic [7:0]           arlen
);
  localparam logic [LEN_WIDTH-1:0] MAX = LEN_WIDTH'(BURST_LEN);
  always_comb begin
    beats = (remaining > MAX) ? 9'(BURST_LEN) : remaining[8:0];
    arlen = 8'(beats - 9'd1);
  end
endmodule

// File: rtl/ddr_rd_ctrl.sv
// ddr_rd_ctrl: splits a line read into single-outstanding AXI4 bursts and forwards beats; DDR_RD_DROP_CNT_EN adds rd_drop_cnt
module ddr_rd_ctrl import ddr_rd_pkg::*; #(
  parameter int ADDR_WIDTH = 27,
  parameter int DQ_WIDTH   = DDR_DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16,
  parameter int BURST_LEN  = 16
) (
  input  logic                  ddr_clk,
  input  logic                  ddr_rst,
`ifdef DDR_RD_DROP_CNT_EN
  output logic [15:0]           rd_drop_cnt,
`endif
  input  logic                  ddr_rreq,
  input  logic [ADDR_WIDTH-1:0] ddr_raddr,
  input  logic [LEN_WIDTH-1:0]  ddr_rd_len,
  output logic                  ddr_rrdy,
  output logic [8*DQ_WIDTH-1:0] ddr_rdata,
  output logic                  ddr_rdata_en,
  output logic                  ddr_rdone,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [8*DQ_WIDTH-1:0] axi_rdata,
  input  logic                  axi_rvalid,
  input  logic                  axi_rlast,
  output logic                  axi_rready
);
  state_t                st;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  rem, calc_in;
  logic [7:0]            cnt, calc_len;
  logic [8:0]            beats;
  logic                  unused_rlast;
  assign unused_rlast = axi_rlast;
  assign calc_in = (st == IDLE) ? ddr_rd_len : rem;
  ddr_rd_burst_calc #(.LEN_WIDTH(LEN_WIDTH), .BURST_LEN(BURST_LEN)) u_calc (
    .remaining(calc_in),
    .beats(beats),
    .arlen(calc_len)
  );
  // beat count, not rlast, closes a burst
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      st           <= IDLE;
      ddr_rrdy     <= 1'b0;
      ddr_rdata    <= '0;
      ddr_rdata_en <= 1'b0;
      ddr_rdone    <= 1'b0;
      axi_araddr   <= '0;
      axi_arlen    <= '0;
      axi_arvalid  <= 1'b0;
      axi_rready   <= 1'b0;
      addr         <= '0;
      rem          <= '0;
      cnt          <= '0;
    end else begin
      ddr_rdata_en <= 1'b0;
      ddr_rdone    <= 1'b0;
      case (st)
        IDLE: if (ddr_rreq && ddr_rrdy) begin
          addr        <= ddr_raddr;
          rem         <= ddr_rd_len;
          ddr_rrdy    <= 1'b0;
          axi_araddr  <= ddr_raddr;
          axi_arlen   <= calc_len;
          axi_arvalid <= ddr_rd_len != '0;
          ddr_rdone   <= ddr_rd_len == '0;
          st          <= (ddr_rd_len == '0) ? DONE : AR;
        end else ddr_rrdy <= 1'b1;
        AR: if (axi_arready) begin
          axi_arvalid <= 1'b0;
          axi_rready  <= 1'b1;
          cnt         <= '0;
          rem         <= rem - LEN_WIDTH'(beats);
          addr        <= addr + ADDR_WIDTH'(beats * BEAT_ADDR_INC);
          st          <= DATA;
        end
        DATA: if (axi_rvalid) begin
          ddr_rdata    <= axi_rdata;
          ddr_rdata_en <= 1'b1;
          cnt          <= cnt + 8'd1;
          if (cnt == axi_arlen) begin
            axi_rready  <= 1'b0;
            axi_araddr  <= addr;
            axi_arlen   <= calc_len;
            axi_arvalid <= rem != '0;
            ddr_rdone   <= rem == '0;
            st          <= (rem == '0) ? DONE : AR;
          end
        end
        DONE: begin
          ddr_rrdy <= 1'b1;
          st       <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
`ifdef DDR_RD_DROP_CNT_EN
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) rd_drop_cnt <= '0;
    else if (ddr_rreq && !ddr_rrdy && rd_drop_cnt != 16'hFFFF) rd_drop_cnt <= rd_drop_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_ddr_rd_ctrl.sv
// tb_ddr_rd_ctrl: directed checks of ddr_rd_ctrl with a small single-burst AXI read slave
module tb_ddr_rd_ctrl;
  logic         ddr_clk, ddr_rst, ddr_rreq, ddr_rrdy, ddr_rdata_en, ddr_rdone;
  logic [26:0]  ddr_raddr, axi_araddr;
  logic [15:0]  ddr_rd_len;
  logic [255:0] ddr_rdata, axi_rdata;
  logic [7:0]   axi_arlen;
  logic         axi_arvalid, axi_arready, axi_rvalid, axi_rlast, axi_rready;
`ifdef DDR_RD_DROP_CNT_EN
  logic [15:0]  rd_drop_cnt;
`endif
  int vectors = 0, miscompares = 0;
  int n_ar, n_arv, n_en, n_done;
  logic [31:0] data_base;
  logic [26:0] ar_log [32];
  logic [7:0]  arlen_log [32];

  ddr_rd_ctrl dut (
    .ddr_clk(ddr_clk), .ddr_rst(ddr_rst),
`ifdef DDR_RD_DROP_CNT_EN
    .rd_drop_cnt(rd_drop_cnt),
`endif
    .ddr_rreq(ddr_rreq), .ddr_raddr(ddr_raddr), .ddr_rd_len(ddr_rd_len), .ddr_rrdy(ddr_rrdy),
    .ddr_rdata(ddr_rdata), .ddr_rdata_en(ddr_rdata_en), .ddr_rdone(ddr_rdone),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast), .axi_rready(axi_rready)
  );

  initial ddr_clk = 1'b0;
  always #5 ddr_clk = ~ddr_clk;

  task automatic tick;
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [26:0] a, input logic [15:0] l);
    chk("rrdy_idle", ddr_rrdy, 1'b1);
    ddr_rreq = 1'b1;
    ddr_raddr = a;
    ddr_rd_len = l;
    tick;
    ddr_rreq = 1'b0;
    chk("rrdy_low", ddr_rrdy, 1'b0);
    chk("arvalid_n1", axi_arvalid, l != 0);
    chk("rdone_n1", ddr_rdone, l == 0);
  endtask

  // per cycle: check last edge's outputs, then drive the slave for the next edge
  task automatic serve(input int ar_delay, input bit toggle, input int drop_at, input int stop_at);
    int cyc, wait_cnt, left;
    bit fin, acc, hs, phase;
    logic [31:0] dn, de;
    logic [26:0] hold_addr;
    logic [7:0]  hold_len;
    cyc = 0; wait_cnt = 0; left = 0;
    fin = 0; acc = 0; hs = 0; phase = 0;
    dn = data_base; de = data_base;
    hold_addr = '0; hold_len = '0;
    n_ar = 0; n_arv = 0; n_en = 0; n_done = 0;
    while (!fin && cyc < 4000) begin
      chk("en_latency", ddr_rdata_en, acc);
      if (ddr_rdata_en) begin
        chk("rdata", ddr_rdata, 256'(de));
        de++;
        n_en++;
      end
      if (axi_arvalid) n_arv++;
      if (ddr_rdone) begin
        n_done++;
        fin = 1;
        ddr_rreq = 1'b0;
        axi_arready = 1'b0;
        axi_rvalid = 1'b0;
        tick;
        chk("rdone_pulse", ddr_rdone, 1'b0);
        chk("rrdy_after_done", ddr_rrdy, 1'b1);
      end else if (cyc == stop_at) begin
        fin = 1;
      end else begin
        if (axi_arvalid && wait_cnt == 0) begin
          hold_addr = axi_araddr;
          hold_len = axi_arlen;
        end else if (axi_arvalid) begin
          chk("araddr_hold", axi_araddr, hold_addr);
          chk("arlen_hold", axi_arlen, hold_len);
        end
        axi_arready = axi_arvalid && wait_cnt >= ar_delay;
        axi_rvalid = left > 0 && (!toggle || phase);
        axi_rlast = left == 1;
        axi_rdata = 256'(dn);
        ddr_rreq = cyc == drop_at;
        ddr_raddr = 27'h3C0;
        ddr_rd_len = 16'd7;
        acc = axi_rvalid && axi_rready;
        hs = axi_arvalid && axi_arready;
        if (hs) begin
          ar_log[n_ar] = axi_araddr;
          arlen_log[n_ar] = axi_arlen;
        end
        if (axi_arvalid && !hs) wait_cnt++;
        tick;
        phase = !phase;
        if (acc) begin
          left--;
          dn++;
        end
        if (hs) begin
          left = int'(arlen_log[n_ar]) + 1;
          n_ar++;
          wait_cnt = 0;
        end
      end
      cyc++;
    end
    chk("finished", fin, 1'b1);
    ddr_rreq = 1'b0;
  endtask

  initial begin
    ddr_rst = 1'b1; ddr_rreq = 1'b0; ddr_raddr = '0; ddr_rd_len = '0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = '0;
    tick;
    tick;
    chk("rst_rrdy", ddr_rrdy, 1'b0);
    chk("rst_arvalid", axi_arvalid, 1'b0);
    chk("rst_rready", axi_rready, 1'b0);
    chk("rst_en", ddr_rdata_en, 1'b0);
    chk("rst_rdone", ddr_rdone, 1'b0);
    chk("rst_rdata", ddr_rdata, 256'd0);
    chk("rst_araddr", axi_araddr, 27'd0);
    chk("rst_arlen", axi_arlen, 8'd0);
    ddr_rst = 1'b0;
    tick;
    chk("rrdy_after_rst", ddr_rrdy, 1'b1);

    data_base = 32'h1000;
    req(27'd0, 16'd180);
    serve(0, 0, -1, -1);
    chk("line_ar_count", n_ar, 12);
    for (int i = 0; i < 12; i++) begin
      chk("line_araddr", ar_log[i], 27'(i * 128));
      chk("line_arlen", arlen_log[i], (i < 11) ? 8'd15 : 8'd3);
    end
    chk("line_beats", n_en, 180);
    chk("line_done", n_done, 1);

    req(27'h55, 16'd0);
    serve(0, 0, -1, -1);
    chk("len0_arvalid", n_arv, 0);
    chk("len0_done", n_done, 1);

    data_base = 32'h2000;
    req(27'h100, 16'd16);
    serve(5, 1, -1, -1);
    chk("stall_ar_count", n_ar, 1);
    chk("stall_araddr", ar_log[0], 27'h100);
    chk("stall_arlen", arlen_log[0], 8'd15);
    chk("stall_beats", n_en, 16);

    data_base = 32'h3000;
    req(27'h200, 16'd16);
    serve(0, 0, 3, -1);
    chk("drop_ar_count", n_ar, 1);
    chk("drop_araddr", ar_log[0], 27'h200);
    chk("drop_beats", n_en, 16);
`ifdef DDR_RD_DROP_CNT_EN
    chk("drop_cnt", rd_drop_cnt, 16'd1);
`endif

    data_base = 32'h4000;
    req(27'h7FFFFC0, 16'd24);
    serve(0, 0, -1, -1);
    chk("wrap_ar_count", n_ar, 2);
    chk("wrap_araddr0", ar_log[0], 27'h7FFFFC0);
    chk("wrap_arlen0", arlen_log[0], 8'd15);
    chk("wrap_araddr1", ar_log[1], 27'd64);
    chk("wrap_arlen1", arlen_log[1], 8'd7);
    chk("wrap_beats", n_en, 24);

    data_base = 32'h5000;
    req(27'h0, 16'd32);
    serve(0, 0, -1, 6);
    ddr_rst = 1'b1;
    axi_arready = 1'b0;
    axi_rvalid = 1'b0;
    tick;
    chk("mid_rst_rrdy", ddr_rrdy, 1'b0);
    chk("mid_rst_rready", axi_rready, 1'b0);
    chk("mid_rst_arvalid", axi_arvalid, 1'b0);
    chk("mid_rst_en", ddr_rdata_en, 1'b0);
    chk("mid_rst_rdone", ddr_rdone, 1'b0);
    chk("mid_rst_rdata", ddr_rdata, 256'd0);
    chk("mid_rst_araddr", axi_araddr, 27'd0);
    chk("mid_rst_arlen", axi_arlen, 8'd0);
    ddr_rst = 1'b0;
    tick;
    chk("mid_rst_rrdy_after", ddr_rrdy, 1'b1);
`ifdef DDR_RD_DROP_CNT_EN
    chk("drop_cnt_cleared", rd_drop_cnt, 16'd0);
`endif

    data_base = 32'h6000;
    req(27'h40, 16'd1);
    serve(0, 0, -1, -1);
    chk("recover_ar_count", n_ar, 1);
    chk("recover_araddr", ar_log[0], 27'h40);
    chk("recover_arlen", arlen_log[0], 8'd0);
    chk("recover_beats", n_en, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
